c499_sec_encoder: RTL and testbench
===================================

# c499_sec_encoder

Byte-serial single-error-correcting encoder and the transmit end of the c499 SEC channel. It collects a 32-bit data word as four byte beats on a valid/ready input and computes the 8 check bits. It presents a registered codeword {data, check, R} on a valid/ready output. A codeword from this block, fed unmodified into the c499 decoder, gives syndrome 0 and passes the data through uncorrected.

## Interface
- CNT_W, default 16: width of the encoded-word counter.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  byte beat offered.
- in_ready  output  1  beat accepted when in_valid && in_ready.
- in_byte  input  8  data byte; beat n carries d[8n+j] on in_byte[j], n = 0..3.
- out_valid  output  1  codeword held in output register.
- out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
- out_data  output  32  out_data[k] = d[k]; maps to decoder ID[k].
- out_check  output  8  out_check[k] = Ck; maps to decoder IC[k].
- out_r  output  1  redundancy enable; 1 whenever out_valid is 1.
- beat_idx  output  2  index of the next expected beat.
- words_sent  output  CNT_W  count of codewords transferred on the output; wraps modulo 2^CNT_W.

## Operation
- Check equations; ^ over listed d indices:
  - C0 = 0,4,8,12,16..23
  - C1 = 1,5,9,13,24..31
  - C2 = 2,6,10,14,16..19,24..27
  - C3 = 3,7,11,15,20..23,28..31
  - C4 = 16,20,24,28,0..7
  - C5 = 17,21,25,29,8..15
  - C6 = 18,22,26,30,0..3,8..11
  - C7 = 19,23,27,31,4..7,12..15
- Each Ck has 12 terms, so an all-ones word encodes to check 0x00.
- Beat counter states: B0, B1, B2, B3.
  - Accepted beat in Bn stores the byte in assembly bits [8n+7:8n].
  - Bn advances to B(n+1); B3 advances to B0.
- Final beat (accepted in B3):
  - Assemble the word from the three stored bytes plus the current in_byte.
  - Compute C0..C7 combinationally.
  - Load out_data, out_check, out_r=1 and set out_valid.
- in_ready:
  - B0..B2: in_ready = 1.
  - B3: in_ready = !out_valid || out_ready.
  - This gives a full-rate stream of one word per 4 cycles when out_ready is held high.
- Output register:
  - Holds its contents stable while out_valid && !out_ready.
  - Clears out_valid on transfer unless a final beat loads a new word in the same cycle. In that case out_valid stays 1 and the new word replaces the old one.
- words_sent increments by 1 on each output transfer.
- in_byte is ignored when in_valid = 0 and no state changes.

## Timing
- Reset (rst = 1 at a rising edge) sets:
  - beat_idx = 0
  - out_valid = 0
  - out_data = 0
  - out_check = 0
  - out_r = 0
  - words_sent = 0
  - assembly register = 0
  - in_ready = 1 in the cycle after reset
- Reset mid-word discards the partial word. Reset with out_valid = 1 drops the pending codeword, and that codeword is not counted.
- Latency: a final beat accepted at edge t gives out_valid = 1 with the codeword after edge t.
- No combinational path from in_byte to the output ports.
- No combinational path between in_valid and in_ready; in_ready depends only on beat_idx, out_valid and out_ready.
- Simultaneous final-beat acceptance and output transfer:
  - The old word is transferred and counted.
  - The new word is loaded.
  - out_valid remains 1 with no bubble.
- Backpressure: while out_valid = 1 and out_ready = 0, beats 0..2 of the next word may still be accepted. The block then stalls in B3.
- Counter wrap: words_sent goes from 2^CNT_W-1 to 0 on the next transfer.

## Test plan
- Zero word: bytes 00,00,00,00 with out_ready = 1 -> out_data = 0x00000000, out_check = 0x00, out_r = 1, out_valid for 1 cycle, words_sent = 1.
- Single-bit words, each fed as four beats:
  - d0 = 1 (bytes 01,00,00,00) -> out_check = 0x51.
  - d16 = 1 (bytes 00,00,01,00) -> out_check = 0x15.
  - d31 = 1 (bytes 00,00,00,80) -> out_check = 0x8A.
  - All ones (FF x4) -> out_check = 0x00.
- Backpressure: hold out_ready = 0 after word A, then stream 4 beats of word B.
  - Beats 0..2 are accepted and in_ready = 0 in B3.
  - out_data stays equal to A.
  - Raise out_ready for 1 cycle -> A transferred and B loaded in the same edge; out_valid stays 1.
- Continuous stream: 100 random words with in_valid = 1 and out_ready = 1.
  - One word every 4 cycles.
  - Each codeword, passed to the c499 decoder with R = out_r, yields OD = out_data and syndrome 0.
  - words_sent = 100.
- Reset mid-word: assert rst after 2 beats -> beat_idx = 0, out_valid = 0. The next 4 beats produce only the fresh word.
- Wrap: CNT_W = 2 and 5 transfers -> words_sent = 1.

Source files
------------

// File: rtl/c499_sec_encoder.sv
// Byte-serial SEC encoder: gathers four data bytes and emits a registered
// {data, check, R} codeword for the c499 SEC decoder over valid/ready.
module c499_sec_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [7:0]       i_in_byte,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [31:0]      o_out_data,
  output logic [7:0]       o_out_check,
  output logic             o_out_r,
  output logic [1:0]       o_beat_idx,
  output logic [CNT_W-1:0] o_words_sent
);

  typedef enum logic [1:0] {B0, B1, B2, B3} beat_e;

  // Each row selects the 12 data bits that parity into one check bit.
  localparam logic [7:0][31:0] CHK_MASK = {
    32'h8888F0F0, 32'h44440F0F, 32'h2222FF00, 32'h111100FF,
    32'hF0F08888, 32'h0F0F4444, 32'hFF002222, 32'h00FF1111
  };

  beat_e            r_beat;
  logic [23:0]      r_asm;
  logic             r_out_valid;
  logic [31:0]      r_out_data;
  logic [7:0]       r_out_check;
  logic             r_out_r;
  logic [CNT_W-1:0] r_words_sent;

  logic        w_in_ready;
  logic        w_accept;
  logic        w_final;
  logic        w_xfer;
  logic [31:0] w_word;
  logic [7:0]  w_check;

  assign w_in_ready = (r_beat != B3) || !r_out_valid || i_out_ready;
  assign w_accept   = i_in_valid && w_in_ready;
  assign w_final    = w_accept && (r_beat == B3);
  assign w_xfer     = r_out_valid && i_out_ready;
  assign w_word     = {i_in_byte, r_asm};

  always_comb begin
    w_check = '0;
    for (int k = 0; k < 8; k++) w_check[k] = ^(w_word & CHK_MASK[k]);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_beat       <= B0;
      r_asm        <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_check  <= '0;
      r_out_r      <= 1'b0;
      r_words_sent <= '0;
    end else begin
      if (w_accept) begin
        case (r_beat)
          B0: r_asm[7:0]   <= i_in_byte;
          B1: r_asm[15:8]  <= i_in_byte;
          B2: r_asm[23:16] <= i_in_byte;
          default: ;
        endcase
        r_beat <= beat_e'(r_beat + 2'd1);
      end
      // A final beat wins over a transfer so back-to-back words leave no bubble.
      if (w_final) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_word;
        r_out_check <= w_check;
        r_out_r     <= 1'b1;
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end
      if (w_xfer) r_words_sent <= r_words_sent + 1'b1;
    end
  end

  assign o_in_ready   = w_in_ready;
  assign o_out_valid  = r_out_valid;
  assign o_out_data   = r_out_data;
  assign o_out_check  = r_out_check;
  assign o_out_r      = r_out_r;
  assign o_beat_idx   = r_beat;
  assign o_words_sent = r_words_sent;

endmodule

// File: tb/tb_c499_sec_encoder.sv
// Directed bench for c499_sec_encoder with an output scoreboard; a second
// instance with a 2-bit counter shares all inputs to exercise counter wrap.
module tb_c499_sec_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        out_ready;

  logic        in_ready,  w_in_ready;
  logic        out_valid, w_out_valid;
  logic [31:0] out_data,  w_out_data;
  logic [7:0]  out_check, w_out_check;
  logic        out_r,     w_out_r;
  logic [1:0]  beat_idx,  w_beat_idx;
  logic [15:0] words_sent;
  logic [1:0]  w_words_sent;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int exp_sent = 0;
  logic [39:0] sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  c499_sec_encoder u_dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_byte(in_byte), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_data(out_data), .o_out_check(out_check), .o_out_r(out_r),
    .o_beat_idx(beat_idx), .o_words_sent(words_sent)
  );

  c499_sec_encoder #(.CNT_W(2)) u_wrap (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(w_in_ready),
    .i_in_byte(in_byte), .o_out_valid(w_out_valid), .i_out_ready(out_ready),
    .o_out_data(w_out_data), .o_out_check(w_out_check), .o_out_r(w_out_r),
    .o_beat_idx(w_beat_idx), .o_words_sent(w_words_sent)
  );

  // Reference check bits, written from the index lists of each equation.
  function automatic logic [7:0] enc(input logic [31:0] d);
    logic [7:0] c;
    c[0] = d[0] ^ d[4] ^ d[8]  ^ d[12] ^ (^d[23:16]);
    c[1] = d[1] ^ d[5] ^ d[9]  ^ d[13] ^ (^d[31:24]);
    c[2] = d[2] ^ d[6] ^ d[10] ^ d[14] ^ (^d[19:16]) ^ (^d[27:24]);
    c[3] = d[3] ^ d[7] ^ d[11] ^ d[15] ^ (^d[23:20]) ^ (^d[31:28]);
    c[4] = d[16] ^ d[20] ^ d[24] ^ d[28] ^ (^d[7:0]);
    c[5] = d[17] ^ d[21] ^ d[25] ^ d[29] ^ (^d[15:8]);
    c[6] = d[18] ^ d[22] ^ d[26] ^ d[30] ^ (^d[3:0]) ^ (^d[11:8]);
    c[7] = d[19] ^ d[23] ^ d[27] ^ d[31] ^ (^d[7:4]) ^ (^d[15:12]);
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: a transfer happens at the next rising edge when valid&&ready here.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) chk("sb_unexpected_word", 32'd1, 32'd0);
      else begin
        logic [39:0] e;
        e = sb_q.pop_front();
        chk("sb_data", out_data, e[39:8]);
        chk("sb_check", {24'd0, out_check}, {24'd0, e[7:0]});
        chk("sb_r", {31'd0, out_r}, 32'd1);
        chk("dec_syndrome", {24'd0, enc(out_data) ^ out_check}, 32'd0);
      end
      exp_sent++;
    end
  end

  task automatic send_beat(input logic [7:0] b);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_byte  = b;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("beat_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int n = 0; n < 3; n++) send_beat(w[8*n +: 8]);
    sb_q.push_back({w, enc(w)});
    send_beat(w[31:24]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    exp_sent = 0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    out_ready = 1'b1;
    while (sb_q.size() != 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_queue_empty", sb_q.size(), 32'd0);
  endtask

  logic [31:0] single_w[4] = '{32'h0000_0001, 32'h0001_0000, 32'h8000_0000, 32'hFFFF_FFFF};
  logic [7:0]  single_c[4] = '{8'h51, 8'h15, 8'h8A, 8'h00};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wa, wb;
    int t0;
    rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b0;
    do_reset();

    @(negedge clk);
    chk("rst_beat_idx", {30'd0, beat_idx}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_check", {24'd0, out_check}, 32'd0);
    chk("rst_out_r", {31'd0, out_r}, 32'd0);
    chk("rst_words_sent", {16'd0, words_sent}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Zero word; single-cycle valid with out_ready held high
    out_ready = 1'b1;
    send_word(32'h0);
    chk("zero_valid", {31'd0, out_valid}, 32'd1);
    chk("zero_check", {24'd0, out_check}, 32'd0);
    chk("zero_r", {31'd0, out_r}, 32'd1);
    @(posedge clk); #1;
    chk("zero_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("zero_words_sent", {16'd0, words_sent}, 32'd1);

    for (int i = 0; i < 4; i++) begin
      send_word(single_w[i]);
      chk($sformatf("single%0d_check", i), {24'd0, out_check}, {24'd0, single_c[i]});
      @(posedge clk); #1;
    end
    chk("words_sent_5", {16'd0, words_sent}, 32'd5);
    chk("wrap_words_sent", {30'd0, w_words_sent}, 32'd1);

    // Backpressure: A held, B stalls at its final beat, then both move in one edge
    out_ready = 1'b0;
    wa = 32'hA5C3_1E77;
    wb = 32'h0F1E_2D3C;
    send_word(wa);
    for (int n = 0; n < 3; n++) send_beat(wb[8*n +: 8]);
    in_valid = 1'b1;
    in_byte  = wb[31:24];
    @(negedge clk);
    chk("bp_in_ready_b3", {31'd0, in_ready}, 32'd0);
    chk("bp_beat_idx", {30'd0, beat_idx}, 32'd3);
    chk("bp_hold_data", out_data, wa);
    @(posedge clk); #1;
    chk("bp_hold_data2", out_data, wa);
    sb_q.push_back({wb, enc(wb)});
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("bp_valid_kept", {31'd0, out_valid}, 32'd1);
    chk("bp_new_data", out_data, wb);
    chk("bp_words_sent", {16'd0, words_sent}, 32'd6);
    drain();
    @(posedge clk); #1;
    chk("bp_words_sent_final", {16'd0, words_sent}, 32'd7);

    // Continuous stream of 100 random words
    do_reset();
    out_ready = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 100; i++) send_word($urandom);
    chk("stream_cycles", cyc - t0, 32'd400);
    drain();
    @(posedge clk); #1;
    chk("stream_words_sent", {16'd0, words_sent}, 32'd100);
    chk("stream_tb_count", exp_sent, 32'd100);
    chk("stream_wrap_count", {30'd0, w_words_sent}, 32'd0);

    // Reset after two beats discards the partial word
    send_beat(8'h11);
    send_beat(8'h22);
    chk("mid_beat_idx_pre", {30'd0, beat_idx}, 32'd2);
    do_reset();
    @(negedge clk);
    chk("mid_beat_idx", {30'd0, beat_idx}, 32'd0);
    chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_words_sent", {16'd0, words_sent}, 32'd0);
    @(posedge clk); #1;
    send_word(32'hDEAD_BEEF);
    chk("mid_fresh_data", out_data, 32'hDEAD_BEEF);
    drain();
    @(posedge clk); #1;
    chk("mid_fresh_count", {16'd0, words_sent}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
